// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment capture block.
//   - Segment patterns for digits 0..9, active-low, bit6 = a .. bit0 = g.
//   - Active-low digit enable values for each position plus the blank value.
//   - Position index type and small helpers that classify an enable value.
package seg_pkg;

   localparam logic [6:0] SegDig0 = 7'b0000001;
   localparam logic [6:0] SegDig1 = 7'b1001111;
   localparam logic [6:0] SegDig2 = 7'b0010010;
   localparam logic [6:0] SegDig3 = 7'b0000110;
   localparam logic [6:0] SegDig4 = 7'b1001100;
   localparam logic [6:0] SegDig5 = 7'b0100100;
   localparam logic [6:0] SegDig6 = 7'b0100000;
   localparam logic [6:0] SegDig7 = 7'b0001111;
   localparam logic [6:0] SegDig8 = 7'b0000000;
   localparam logic [6:0] SegDig9 = 7'b0000100;

   localparam logic [3:0] EnBlank = 4'b1111;
   // The leftmost enable bit drives position a.
   localparam logic [3:0] EnPosA  = 4'b0111;
   localparam logic [3:0] EnPosB  = 4'b1011;
   localparam logic [3:0] EnPosC  = 4'b1101;
   localparam logic [3:0] EnPosD  = 4'b1110;

   typedef enum logic [1:0] {
      PosA = 2'd0,
      PosB = 2'd1,
      PosC = 2'd2,
      PosD = 2'd3
   } pos_e;

   // True when exactly one position is enabled.
   function automatic logic en_onehot_low(input logic [3:0] en);
      return (en == EnPosA) || (en == EnPosB) || (en == EnPosC) || (en == EnPosD);
   endfunction

   // Position selected by a one-hot-low enable; other values map to PosA and
   // must be qualified with en_onehot_low().
   function automatic pos_e en_to_pos(input logic [3:0] en);
      pos_e pos;
      case (en)
         EnPosB:  pos = PosB;
         EnPosC:  pos = PosC;
         EnPosD:  pos = PosD;
         default: pos = PosA;
      endcase
      return pos;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment pattern decoder.
//   seg_i   [6:0] : segment pattern, active-low, bit6 = a .. bit0 = g
//   digit_o [3:0] : decoded digit 0..9, 4'hF when the pattern is not a digit
//   err_o         : 1 when the pattern is not one of the ten digit patterns
module seg7_decode
   import seg_pkg::*;
(
   input  logic [6:0] seg_i,
   output logic [3:0] digit_o,
   output logic       err_o
);

   always_comb begin
      digit_o = 4'hF;
      err_o   = 1'b0;
      case (seg_i)
         SegDig0: digit_o = 4'd0;
         SegDig1: digit_o = 4'd1;
         SegDig2: digit_o = 4'd2;
         SegDig3: digit_o = 4'd3;
         SegDig4: digit_o = 4'd4;
         SegDig5: digit_o = 4'd5;
         SegDig6: digit_o = 4'd6;
         SegDig7: digit_o = 4'd7;
         SegDig8: digit_o = 4'd8;
         SegDig9: digit_o = 4'd9;
         default: err_o   = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg_capture.sv
// Captures a multiplexed four-digit seven-segment display into per-position
// digits and publishes a frame once every lit position has been seen.
//   clk, rst          : clock, synchronous active-high reset
//   a_to_g [7:0]      : segments, active-low, bit7 = dp, bits6..0 = a..g
//   en [3:0]          : digit enables, active-low, 0111 = a .. 1110 = d
//   a, b, c, d [3:0]  : decoded digit per position in the last published frame
//   dd [3:0]          : decimal point per position (bit0 = a), 1 = lit
//   present [3:0]     : positions seen lit in the last frame (bit0 = a)
//   seg_err [3:0]     : positions that carried an undecodable pattern
//   frame_valid       : one-cycle pulse when the frame outputs update
// Build option: define SEG_CAPTURE_DP_EN to capture the decimal point (bit7)
// into dd and include it in the stability compare; otherwise dd stays 0.
module seg_capture
   import seg_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES  = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1 << 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] a_to_g,
   input  logic [3:0] en,
   output logic [3:0] a,
   output logic [3:0] b,
   output logic [3:0] c,
   output logic [3:0] d,
   output logic [3:0] dd,
   output logic [3:0] present,
   output logic [3:0] seg_err,
   output logic       frame_valid
);

   // Counter saturates one above STABLE_CYCLES so a long run accepts only once.
   localparam int unsigned CntW  = $clog2(STABLE_CYCLES + 2);
   localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES + 1);

   logic [7:0]       seg_q;
   logic [3:0]       en_q;
   logic [11:0]      key, key_q;
   logic [CntW-1:0]  cnt_q, cnt_now;
   logic [IdleW-1:0] idle_q, idle_d;
   logic             accept, timeout, publish;
   pos_e             pos;
   logic [3:0]       dec_digit;
   logic             dec_err;
   logic             dp_lit;

   logic [3:0][3:0]  work_digit_q, work_digit_d;
   logic [3:0]       work_dp_q, work_dp_d;
   logic [3:0]       work_err_q, work_err_d;
   logic [3:0]       seen_q, seen_d;
   logic [3:0][3:0]  out_digit_q, out_digit_d;
   logic [3:0]       out_dp_q, out_dp_d;
   logic [3:0]       out_err_q, out_err_d;
   logic [3:0]       present_q, present_d;
   logic             fv_q, fv_d;

`ifdef SEG_CAPTURE_DP_EN
   assign key    = {en_q, seg_q};
   assign dp_lit = ~seg_q[7];
`else
   logic unused_dp;
   assign unused_dp = seg_q[7];
   assign key       = {en_q, 1'b0, seg_q[6:0]};
   assign dp_lit    = 1'b0;
`endif

   seg7_decode u_decode (
      .seg_i   (seg_q[6:0]),
      .digit_o (dec_digit),
      .err_o   (dec_err)
   );

   // Length of the current run of identical samples, including this cycle.
   always_comb begin
      if (key != key_q) begin
         cnt_now = CntW'(1);
      end else if (cnt_q > CntW'(STABLE_CYCLES)) begin
         cnt_now = cnt_q;
      end else begin
         cnt_now = cnt_q + CntW'(1);
      end
   end

   assign pos     = en_to_pos(en_q);
   assign accept  = en_onehot_low(en_q) && (cnt_now == CntW'(STABLE_CYCLES));
   // An acceptance counts as activity, so a coinciding timeout is dropped.
   assign timeout = !accept && (idle_q == IdleW'(TIMEOUT_CYCLES - 1));
   assign publish = (accept && seen_q[pos]) || timeout;

   always_comb begin
      if (accept) begin
         idle_d = '0;
      end else if (idle_q == IdleW'(TIMEOUT_CYCLES)) begin
         idle_d = idle_q;  // hold after one timeout until the next acceptance
      end else begin
         idle_d = idle_q + IdleW'(1);
      end
   end

   always_comb begin
      work_digit_d = work_digit_q;
      work_dp_d    = work_dp_q;
      work_err_d   = work_err_q;
      seen_d       = seen_q;
      out_digit_d  = out_digit_q;
      out_dp_d     = out_dp_q;
      out_err_d    = out_err_q;
      present_d    = present_q;
      fv_d         = 1'b0;

      // Publish before recording so a repeated position starts the new frame.
      if (publish) begin
         for (int p = 0; p < 4; p++) begin
            if (seen_q[p]) begin
               out_digit_d[p] = work_digit_q[p];
               out_dp_d[p]    = work_dp_q[p];
               out_err_d[p]   = work_err_q[p];
            end
         end
         present_d = seen_q;
         fv_d      = 1'b1;
         seen_d    = '0;
      end

      if (accept) begin
         work_digit_d[pos] = dec_digit;
         work_dp_d[pos]    = dp_lit;
         work_err_d[pos]   = dec_err;
         seen_d[pos]       = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         seg_q        <= '0;
         en_q         <= '0;
         key_q        <= '0;
         cnt_q        <= '0;
         idle_q       <= '0;
         work_digit_q <= '0;
         work_dp_q    <= '0;
         work_err_q   <= '0;
         seen_q       <= '0;
         out_digit_q  <= '0;
         out_dp_q     <= '0;
         out_err_q    <= '0;
         present_q    <= '0;
         fv_q         <= 1'b0;
      end else begin
         seg_q        <= a_to_g;
         en_q         <= en;
         key_q        <= key;
         cnt_q        <= cnt_now;
         idle_q       <= idle_d;
         work_digit_q <= work_digit_d;
         work_dp_q    <= work_dp_d;
         work_err_q   <= work_err_d;
         seen_q       <= seen_d;
         out_digit_q  <= out_digit_d;
         out_dp_q     <= out_dp_d;
         out_err_q    <= out_err_d;
         present_q    <= present_d;
         fv_q         <= fv_d;
      end
   end

   assign a           = out_digit_q[0];
   assign b           = out_digit_q[1];
   assign c           = out_digit_q[2];
   assign d           = out_digit_q[3];
   assign dd          = out_dp_q;
   assign present     = present_q;
   assign seg_err     = out_err_q;
   assign frame_valid = fv_q;

endmodule
